// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES round controller.
// Holds the FSM state encoding and the per-round key-schedule rotate table.
package des_pkg;

  localparam int unsigned ROUNDS = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRound,
    StFinal,
    StDone
  } state_e;

  localparam logic ShiftDirLeft  = 1'b0;
  localparam logic ShiftDirRight = 1'b1;

  // Decrypt walks the schedule backwards: round 1 uses the unrotated C/D
  // because PC-1(key) already equals C16/D16.
  function automatic logic [1:0] key_shift_amt(input int unsigned ridx, input logic decrypt);
    logic [1:0] amt;
    amt = 2'd2;
    case (ridx)
      0:       amt = decrypt ? 2'd0 : 2'd1;
      1, 8, 15: amt = 2'd1;
      default: amt = 2'd2;
    endcase
    return amt;
  endfunction

endpackage

// File: rtl/des_round_controller_if.sv
// Host/datapath signal bundle for the DES round controller.
// slave is the controller's view; master is the host/datapath side.
interface des_round_controller_if #(
  parameter int unsigned RIDX_W = 4
);

  logic              start;
  logic              decrypt;
  logic              ready;
  logic              busy;
  logic              ip_load;
  logic              key_load;
  logic              round_en;
  logic [RIDX_W-1:0] round_idx;
  logic [1:0]        key_shift_amt;
  logic              key_shift_dir;
  logic              fp_capture;
  logic              out_valid;
  logic              out_ack;

  modport master (
    output start, decrypt, out_ack,
    input  ready, busy, ip_load, key_load, round_en, round_idx,
    input  key_shift_amt, key_shift_dir, fp_capture, out_valid
  );

  modport slave (
    input  start, decrypt, out_ack,
    output ready, busy, ip_load, key_load, round_en, round_idx,
    output key_shift_amt, key_shift_dir, fp_capture, out_valid
  );

endinterface

// File: rtl/des_key_shift_table.sv
// Combinational map from (round index, mode) to the C/D rotate amount.
module des_key_shift_table #(
  parameter int unsigned RIDX_W = 4
) (
  input  logic [RIDX_W-1:0] round_idx_i,
  input  logic              decrypt_i,
  output logic [1:0]        shift_amt_o
);
  import des_pkg::*;

  always_comb begin
    shift_amt_o = key_shift_amt(32'(round_idx_i), decrypt_i);
  end

endmodule

// File: rtl/des_round_controller.sv
// Sequencing FSM for the iterative DES datapath: IP load, ROUNDS Feistel
// rounds (one per cycle), final permutation capture, then a valid/ack hold.
module des_round_controller #(
  parameter int unsigned ROUNDS = 16,
  parameter int unsigned RIDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  des_round_controller_if.slave bus
);
  import des_pkg::*;

  state_e            state_q, state_d;
  logic [RIDX_W-1:0] cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic [1:0]        tbl_amt;

  logic              ready, busy, ip_load, key_load, round_en;
  logic              fp_capture, out_valid, shift_dir;
  logic [RIDX_W-1:0] round_idx;
  logic [1:0]        shift_amt;

  des_key_shift_table #(
    .RIDX_W(RIDX_W)
  ) u_shift_table (
    .round_idx_i(cnt_q),
    .decrypt_i  (mode_q),
    .shift_amt_o(tbl_amt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    ready      = 1'b0;
    busy       = 1'b0;
    ip_load    = 1'b0;
    key_load   = 1'b0;
    round_en   = 1'b0;
    round_idx  = '0;
    shift_amt  = 2'd0;
    shift_dir  = ShiftDirLeft;
    fp_capture = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (bus.start) begin
          mode_d  = bus.decrypt;
          state_d = StLoad;
        end
      end
      StLoad: begin
        busy     = 1'b1;
        ip_load  = 1'b1;
        key_load = 1'b1;
        cnt_d    = '0;
        state_d  = StRound;
      end
      StRound: begin
        busy      = 1'b1;
        round_en  = 1'b1;
        round_idx = cnt_q;
        shift_amt = tbl_amt;
        shift_dir = mode_q ? ShiftDirRight : ShiftDirLeft;
        // Counter holds at the last round so it never wraps inside ROUND.
        if (cnt_q == RIDX_W'(ROUNDS - 1)) begin
          state_d = StFinal;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFinal: begin
        busy       = 1'b1;
        fp_capture = 1'b1;
        state_d    = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (bus.out_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.ready         = ready;
  assign bus.busy          = busy;
  assign bus.ip_load       = ip_load;
  assign bus.key_load      = key_load;
  assign bus.round_en      = round_en;
  assign bus.round_idx     = round_idx;
  assign bus.key_shift_amt = shift_amt;
  assign bus.key_shift_dir = shift_dir;
  assign bus.fp_capture    = fp_capture;
  assign bus.out_valid     = out_valid;

endmodule

// File: doc/des_round_controller.md
Name: des_round_controller

Overview:
Sequencing FSM for the iterative DES datapath: initial permutation, one Feistel round per cycle for 16 cycles, then final permutation.
- Accepts a start request and latches the encrypt/decrypt mode.
- Drives the load, round-enable and capture strobes for the L/R and C/D registers.
- Drives the key-schedule rotate amount and direction for every round.
- Presents the result with a valid/ack handshake.
- Sits between the block-level host interface and the initial_permutation / round / final-permutation / key-schedule datapath.

Parameters:
ROUNDS, 16, number of Feistel rounds; only 16 is legal in production; the shift table is defined for rounds 1..16.
RIDX_W, 4, width of round_idx; must hold ROUNDS-1.

Ports:
clk  input  1  single clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new block; accepted only when ready=1
decrypt  input  1  mode for the request; sampled with start (0 = encrypt, 1 = decrypt)
ready  output  1  controller idle and able to accept start
busy  output  1  operation in progress (LOAD, ROUND or FINAL)
ip_load  output  1  load IP(plain_text) into L0/R0
key_load  output  1  load PC-1(key) into C/D
round_en  output  1  update L/R with one Feistel round this cycle
round_idx  output  RIDX_W  current round, 0..15 (round number minus 1)
key_shift_amt  output  2  C/D rotate amount this cycle: 0, 1 or 2
key_shift_dir  output  1  0 = rotate left (encrypt), 1 = rotate right (decrypt)
fp_capture  output  1  capture FP(R16||L16) into output register
out_valid  output  1  output register holds a result
out_ack  input  1  consumer accepts the result

Behaviour:
- Reset (rst=1 at a clock edge):
  - State becomes IDLE.
  - ready=1; every other output is 0, including round_idx=0 and key_shift_dir=0.
  - Mode register cleared.
  - rst=1 in any state aborts the operation; no fp_capture or out_valid follows.
- States: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE:
  - ready=1.
  - start=1 latches decrypt into the mode register; next state LOAD.
  - start=0: remain in IDLE.
- LOAD (1 cycle):
  - ip_load=1, key_load=1, busy=1.
  - round counter set to 0; next state ROUND.
- ROUND (ROUNDS cycles):
  - round_en=1, busy=1, round_idx = counter, key_shift_dir = latched mode.
  - The rotate is applied combinationally ahead of subkey PC-2 in the same cycle.
  - Encrypt key_shift_amt: 1 for rounds 1, 2, 9, 16; 2 otherwise.
  - Decrypt key_shift_amt: 0 for round 1; 1 for rounds 2, 9, 16; 2 otherwise.
  - Counter increments each cycle; at counter=ROUNDS-1 next state is FINAL.
  - Counter never wraps inside ROUND.
- FINAL (1 cycle):
  - fp_capture=1, busy=1; next state DONE.
- DONE:
  - out_valid=1, held until out_ack=1.
  - out_ack=1 in DONE: next state IDLE.
  - out_ack outside DONE is ignored.
- Latency:
  - start accepted at edge N; LOAD during cycle N+1.
  - Rounds during cycles N+2..N+17; FINAL during N+18.
  - out_valid=1 from cycle N+19.
  - Minimum start-to-start spacing is 20 cycles: one IDLE cycle after ack, no bypass.
- Edge cases:
  - start while not IDLE is ignored; it is not queued.
  - decrypt changes after acceptance have no effect.
  - start and out_ack both high in DONE: only the ack is honoured.
- Per-cycle exclusivity:
  - Exactly one of ip_load, round_en, fp_capture may be high in a cycle.
  - ready, busy and out_valid are mutually exclusive and one is always high.
- Total encrypt rotation over a block is 28, restoring C/D.

Decomposition:
- Package des_pkg holds:
  - the state enum
  - the ROUNDS constant
  - a 16-entry shift-amount function indexed by round_idx and mode
  - shift-direction constants
- Sub-module des_key_shift_table: combinational map from (round_idx, decrypt) to key_shift_amt, unit-testable on its own.
- FSM and counter live in des_round_controller.

Test Plan:
1. Reset, then idle 5 cycles -> ready=1 and all strobes 0 every cycle.
2. Encrypt start at cycle 0:
   - ip_load and key_load at cycle 1.
   - round_en cycles 2..17 with round_idx 0..15.
   - key_shift_amt sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, sum 28.
   - fp_capture cycle 18; out_valid cycle 19.
3. Decrypt start -> key_shift_dir=1 through the rounds; amt sequence 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
4. Hold out_ack=0 for 10 cycles in DONE while pulsing start -> out_valid stays 1, no new LOAD; ack -> IDLE next cycle, ready=1.
5. rst asserted at round_idx=7 -> next cycle IDLE, round_en=0, no fp_capture/out_valid; a new start then runs a clean 16 rounds.
6. Toggle decrypt during ROUND -> shift sequence and direction unchanged from the latched mode.
